// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

  // Controller states; any other encoding is treated as illegal and recovers to RUN.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_t;

  // ResultSrc encoding that marks a load in Execute.
  localparam logic [1:0] RESULT_MEM = 2'b01;

  // True when the load in Execute writes a register the Decode instruction reads.
  // Writes to x0 never create a dependency.
  function automatic logic load_use_hit(
    input logic [1:0] result_src,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return (result_src == RESULT_MEM) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] ONE = width'(1);

  logic [width-1:0] count_reg;

  // Increment on each requested event until all-ones is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait stalls, branch
// flushes and load-use interlocks, plus stall/flush performance counters and
// a sticky memory-timeout flag.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout,
  output logic [1:0]       State
);

  // Wait counter is just wide enough to hold the timeout value; it saturates.
  localparam int               WAIT_W      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(WAIT_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_reg;
  logic              mem_stall;
  logic              load_use;

  // The memory holds the pipeline while waiting, or on the first cycle of a
  // request that is not immediately ready. The cycle MemReadyM rises is the
  // release cycle and is not stalled, so deferred flushes land there.
  assign mem_stall = !MemReadyM &&
                     ((state_reg == MEM_WAIT) || ((state_reg == RUN) && MemReqM));
  assign load_use  = load_use_hit(ResultSrcE, RdE, Rs1D, Rs2D);

  assign wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : (wait_cnt_reg + WAIT_ONE);

  // Prioritised hazard resolution: reset > memory stall > branch flush > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Memory-wait FSM with consecutive-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          wait_cnt_reg <= '0;
          if (MemReqM && !MemReadyM) begin
            state_reg <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          wait_cnt_reg <= wait_cnt_next;
          if (wait_cnt_next >= TIMEOUT_VAL) begin
            timeout_reg <= 1'b1;
          end
          if (MemReadyM) begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign State      = state_reg;
  assign MemTimeout = timeout_reg;

  // Performance counters: index 0 counts stall cycles, index 1 counts flush cycles.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = StallF | StallD | StallE | StallM;
  assign cnt_inc[1] = FlushD | FlushE;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
    sat_counter #(
      .width(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc[gi]),
      .count(cnt_val[gi])
    );
  end

  assign StallCount = cnt_val[0];
  assign FlushCount = cnt_val[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus
// randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 6;
  localparam int TO      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic             MemTimeout;
  logic [1:0]       State;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed in terms of the behavioural rules.
  bit m_known     = 0;
  bit m_waiting   = 0;
  int m_wait_len  = 0;
  bit m_timeout   = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  pipeline_ctrl #(
    .CNT_W       (CNT_W),
    .WAIT_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdE       (RdE),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .StallCount(StallCount),
    .FlushCount(FlushCount),
    .MemTimeout(MemTimeout),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: drive, check at the falling edge, advance the model.
  task automatic drive_cycle(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [1:0] rsrc, input logic pc,
                             input logic req, input logic rdy, input string tag);
    logic [6:0]       exp_ctl, got_ctl;
    logic [1:0]       exp_state;
    logic [CNT_W-1:0] exp_sc, exp_fc;
    bit               mem_stalled, lu;
    rst = r; Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc;
    PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
    @(negedge clk);
    mem_stalled = !r && !rdy && (m_waiting || req);
    lu = (rsrc == 2'b01) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    if (r)                exp_ctl = 7'b0000111;
    else if (mem_stalled) exp_ctl = 7'b1111001;
    else if (pc)          exp_ctl = 7'b0000110;
    else if (lu)          exp_ctl = 7'b1100010;
    else                  exp_ctl = 7'b0000000;
    got_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    n_checks++;
    if (got_ctl !== exp_ctl) begin
      n_fail++;
      $display("FAIL %s ctl: got %b expected %b", tag, got_ctl, exp_ctl);
    end
    if (m_known) begin
      exp_state = m_waiting ? 2'b01 : 2'b00;
      exp_sc = m_stall_cnt[CNT_W-1:0];
      exp_fc = m_flush_cnt[CNT_W-1:0];
      n_checks++;
      if (State !== exp_state) begin
        n_fail++;
        $display("FAIL %s state: got %b expected %b", tag, State, exp_state);
      end
      n_checks++;
      if (StallCount !== exp_sc) begin
        n_fail++;
        $display("FAIL %s stall_count: got %0d expected %0d", tag, StallCount, exp_sc);
      end
      n_checks++;
      if (FlushCount !== exp_fc) begin
        n_fail++;
        $display("FAIL %s flush_count: got %0d expected %0d", tag, FlushCount, exp_fc);
      end
      n_checks++;
      if (MemTimeout !== m_timeout) begin
        n_fail++;
        $display("FAIL %s timeout: got %b expected %b", tag, MemTimeout, m_timeout);
      end
    end
    $display("[%0t] %s rst=%0b rs1=%0d rs2=%0d rd=%0d src=%b pc=%0b req=%0b rdy=%0b ctl=%b st=%b sc=%0d fc=%0d to=%0b",
             $time, tag, r, rs1, rs2, rd, rsrc, pc, req, rdy, got_ctl, State, StallCount,
             FlushCount, MemTimeout);
    @(posedge clk);
    if (r) begin
      m_known = 1; m_waiting = 0; m_wait_len = 0; m_timeout = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (|exp_ctl[6:3] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if ((exp_ctl[2] || exp_ctl[1]) && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (m_waiting) begin
        m_wait_len++;
        if (m_wait_len >= TO) m_timeout = 1;
        m_waiting = !rdy;
      end else begin
        m_wait_len = 0;
        m_waiting = req && !rdy;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive_cycle(1, 0, 0, 0, 2'b00, 0, 0, 1, "reset");
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_checks++;
    if ({State, StallCount, FlushCount, MemTimeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%b sc=%0d fc=%0d to=%b required all zero",
               State, StallCount, FlushCount, MemTimeout);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_cycle(0, 5'd5, 5'd7, 5'd5, 2'b01, 0, 0, 1, "load_use");
    n_checks++;
    if (StallCount !== 1 || FlushCount !== 1) begin
      n_fail++;
      $display("FAIL load_use_counts: got sc=%0d fc=%0d required 1/1", StallCount, FlushCount);
    end
    drive_cycle(0, 5'd5, 5'd7, 5'd6, 2'b00, 0, 0, 1, "after_load_use");
    n_checks++;
    if (StallF !== 1'b0 || StallCount !== 1) begin
      n_fail++;
      $display("FAIL load_use_one_cycle: got StallF=%b sc=%0d required 0/1", StallF, StallCount);
    end
  endtask

  task automatic test_load_x0();
    do_reset();
    drive_cycle(0, 5'd3, 5'd0, 5'd0, 2'b01, 0, 0, 1, "load_x0");
    n_checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b0000 || StallCount !== 0 || FlushCount !== 0) begin
      n_fail++;
      $display("FAIL load_x0: got sf=%b sd=%b fe=%b fd=%b sc=%0d fc=%0d required all 0",
               StallF, StallD, FlushE, FlushD, StallCount, FlushCount);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive_cycle(0, 5'd5, 5'd0, 5'd5, 2'b01, 1, 0, 1, "branch");
    n_checks++;
    if (FlushD !== 1'b1 || FlushE !== 1'b1 || StallF !== 1'b0 || FlushCount !== 1 || StallCount !== 0) begin
      n_fail++;
      $display("FAIL branch: got fd=%b fe=%b sf=%b fc=%0d sc=%0d required 1 1 0 1 0",
               FlushD, FlushE, StallF, FlushCount, StallCount);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 1, 0, "mem_wait1");
    n_checks++;
    if (State !== 2'b01 || {StallF, StallD, StallE, StallM, FlushW} !== 5'b11111) begin
      n_fail++;
      $display("FAIL mem_wait_enter: got st=%b stalls=%b required 01/11111", State,
               {StallF, StallD, StallE, StallM, FlushW});
    end
    drive_cycle(0, 0, 0, 0, 2'b00, 1, 1, 0, "mem_wait2");
    drive_cycle(0, 0, 0, 0, 2'b00, 1, 1, 0, "mem_wait3");
    n_checks++;
    if (StallCount !== 3 || FlushCount !== 0) begin
      n_fail++;
      $display("FAIL mem_wait_count: got sc=%0d fc=%0d required 3/0", StallCount, FlushCount);
    end
    // Branch held behind the stall is applied on the release cycle.
    drive_cycle(0, 0, 0, 0, 2'b00, 1, 1, 1, "mem_release");
    n_checks++;
    if (State !== 2'b00 || StallCount !== 3 || FlushCount !== 1) begin
      n_fail++;
      $display("FAIL mem_release: got st=%b sc=%0d fc=%0d required 00/3/1", State, StallCount,
               FlushCount);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(0, 0, 0, 0, 2'b00, 0, 1, 0, "timeout_wait");
      n_checks++;
      if (MemTimeout !== (k >= 5)) begin
        n_fail++;
        $display("FAIL timeout_rise k=%0d: got %b required %b", k, MemTimeout, (k >= 5));
      end
    end
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 1, 1, "timeout_release");
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 0, 1, "timeout_idle");
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 0, 1, "timeout_idle");
    n_checks++;
    if (MemTimeout !== 1'b1 || State !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_sticky: got to=%b st=%b required 1/00", MemTimeout, State);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive_cycle(0, 0, 0, 0, 2'b00, 1, 0, 1, "pre_branch");
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 1, 0, "midwait1");
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 1, 0, "midwait2");
    drive_cycle(1, 0, 0, 0, 2'b00, 0, 1, 0, "midwait_rst");
    n_checks++;
    if ({FlushD, FlushE, FlushW} !== 3'b111 || {StallF, StallD, StallE, StallM} !== 4'b0000 ||
        State !== 2'b00 || StallCount !== 0 || FlushCount !== 0 || MemTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got fl=%b stl=%b st=%b sc=%0d fc=%0d to=%b required 111/0000/00/0/0/0",
               {FlushD, FlushE, FlushW}, {StallF, StallD, StallE, StallM}, State, StallCount,
               FlushCount, MemTimeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 250; i++) begin
      drive_cycle(($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0), "random");
    end
  endtask

  initial begin
    rst = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0; ResultSrcE = '0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1;
    test_reset();
    test_load_use();
    test_load_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 SHALL have parameter WAIT_TIMEOUT, default 255, maximum MEM_WAIT cycles before the timeout flag is set.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its posedge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 SHALL have port RdE  in  5  destination register of the instruction in Execute.
REQ-007 SHALL have port ResultSrcE  in  2  result select in Execute; 2'b01 marks a load.
REQ-008 SHALL have port PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-009 SHALL have ports MemReqM, MemReadyM  in  1 each  data-memory access in Memory stage, and completion.
REQ-010 SHALL have ports StallF, StallD, StallE, StallM  out  1 each  hold enables for the PC and the D, E, M pipeline registers.
REQ-011 SHALL have ports FlushD, FlushE, FlushW  out  1 each  bubble-insert for the D, E, W pipeline registers.
REQ-012 SHALL have ports StallCount, FlushCount  out  CNT_W each  saturating event counters.
REQ-013 SHALL have ports MemTimeout  out  1  sticky timeout flag; State  out  2  current FSM state.

Function
REQ-014 SHALL implement states RUN (2'b00) and MEM_WAIT (2'b01); all other encodings SHALL return to RUN on the next cycle.
REQ-015 SHALL move RUN->MEM_WAIT when MemReqM=1 and MemReadyM=0; MEM_WAIT->RUN on the cycle MemReadyM=1.
REQ-016 SHALL, while the memory is stalled (MEM_WAIT, or RUN with MemReqM=1 and MemReadyM=0), assert StallF, StallD, StallE, StallM and FlushW, and deassert FlushD and FlushE.
REQ-017 SHALL, otherwise, apply PCSrcE=1 as FlushD=1 and FlushE=1 with no stall in the same cycle.
REQ-018 SHALL, otherwise, detect load-use (ResultSrcE=2'b01, RdE!=0, RdE equals Rs1D or Rs2D) and assert StallF, StallD and FlushE for exactly that cycle.
REQ-019 SHALL use priority memory stall > branch flush > load-use; a flush deferred behind a memory stall SHALL be applied on the release cycle, because PCSrcE is held by StallE.
REQ-020 SHALL drive all Stall/Flush outputs combinationally from the current inputs and state, with zero-cycle latency.
REQ-021 SHALL count one StallCount per cycle with any Stall output high, and one FlushCount per cycle with FlushD or FlushE high; both SHALL saturate at all-ones without wrapping.
REQ-022 SHALL count consecutive MEM_WAIT cycles, set MemTimeout when the count reaches WAIT_TIMEOUT, keep it set until reset, and not alter stalling.

Reset
REQ-023 SHALL, with rst=1 at a posedge, set State=RUN, the wait counter to 0, StallCount and FlushCount to 0, and MemTimeout to 0.
REQ-024 SHALL, while rst=1, drive all Stall outputs to 0 and FlushD, FlushE, FlushW to 1; a reset during MEM_WAIT SHALL abandon the wait.

Structure
REQ-025 SHALL take the state enum and RESULT_MEM=2'b01 from the shared package pipeline_pkg.
REQ-026 SHALL instantiate sub-module sat_counter (parameter width; rst, inc, count) twice, once per performance counter.

Verification
REQ-027 SHALL test load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle; StallCount=1 and FlushCount=1.
REQ-028 SHALL test load to x0: RdE=0, Rs2D=0, ResultSrcE=01 -> no stall and no flush.
REQ-029 SHALL test branch: PCSrcE=1 with a load-use match -> FlushD=FlushE=1, StallF=0.
REQ-030 SHALL test a memory wait: MemReqM=1 with MemReadyM low 3 cycles -> all Stalls and FlushW high 3 cycles, State=01 then 00; StallCount=3.
REQ-031 SHALL test timeout: WAIT_TIMEOUT=4 with MemReadyM low 6 cycles -> MemTimeout rises after the 4th MEM_WAIT cycle and stays high after release.
REQ-032 SHALL test reset mid-wait: rst=1 in MEM_WAIT -> State=00, counters 0, FlushD/E/W=1 during reset.
